// File: rtl/rom_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_read_arbiter
// Purpose  : Round-robin read controller sharing one synchronous-read ROM
//            (one-cycle registered read latency) between N_REQ requesters.
//            Each requester issues single-word or burst reads through a
//            valid/ready handshake. The block drives the ROM address, tracks
//            the read latency and steers the returned word to its owner with
//            a one-hot valid.
//
// Ports    :
//   clk        in   1                  single clock, posedge
//   rst        in   1                  synchronous active-high reset
//   req_valid  in   N_REQ              per-requester request valid
//   req_addr   in   N_REQ*DEPTH_LOG    start address, requester i at
//                                      [i*DEPTH_LOG +: DEPTH_LOG]
//   req_len    in   N_REQ*LEN_W        beats minus one, packed likewise
//   req_ready  out  N_REQ              one-hot grant (combinational)
//   rom_addr   out  DEPTH_LOG          registered ROM read address
//   rom_data   in   WIDTH              ROM read data
//   rsp_valid  out  N_REQ              one-hot owner of rsp_data (registered)
//   rsp_data   out  WIDTH              rom_data pass-through
//   rsp_last   out  1                  final beat of a burst (registered)
//
// Revision : 1.0 - initial release
// ============================================================================
module rom_read_arbiter #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = $clog2(DEPTH),
  parameter int N_REQ     = 2,
  parameter int LEN_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*DEPTH_LOG-1:0]   req_addr,
  input  logic [N_REQ*LEN_W-1:0]       req_len,
  output logic [N_REQ-1:0]             req_ready,
  output logic [DEPTH_LOG-1:0]         rom_addr,
  input  logic [WIDTH-1:0]             rom_data,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [WIDTH-1:0]             rsp_data,
  output logic                         rsp_last
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t                 state_q;
  logic [PTR_W-1:0]       ptr_q;        // round-robin search start
  logic [PTR_W-1:0]       owner_q;      // requester owning the current burst
  logic [LEN_W-1:0]       rem_q;        // beats still to issue after this one
  logic [DEPTH_LOG-1:0]   rom_addr_q;
  logic [N_REQ-1:0]       rsp_valid_q;
  logic                   rsp_last_q;

  // --------------------------------------------------------------------------
  // Grant logic
  // --------------------------------------------------------------------------
  logic                   accept_slot;
  logic                   gnt_any;
  logic [PTR_W-1:0]       gnt_idx;
  logic [N_REQ-1:0]       gnt_onehot;
  logic [DEPTH_LOG-1:0]   gnt_addr;
  logic [LEN_W-1:0]       gnt_len;
  logic [PTR_W-1:0]       ptr_d;
  logic [N_REQ-1:0]       owner_onehot;
  int                     search_idx;

  // A new burst may be granted while idle, or in the final issue cycle of the
  // current burst so that the next burst follows without a bubble.
  assign accept_slot = (state_q == ST_IDLE) || (rem_q == '0);

  // Search upward from ptr_q, wrapping modulo N_REQ; first asserted valid wins.
  // Reset suppresses any grant so no accept can race the reset edge.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    search_idx = 0;
    if (accept_slot && !rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        search_idx = (int'(ptr_q) + k) % N_REQ;
        if (!gnt_any && req_valid[search_idx]) begin
          gnt_any                = 1'b1;
          gnt_onehot[search_idx] = 1'b1;
          gnt_idx                = PTR_W'(search_idx);
        end
      end
    end
  end

  assign gnt_addr = req_addr[gnt_idx*DEPTH_LOG +: DEPTH_LOG];
  assign gnt_len  = req_len[gnt_idx*LEN_W +: LEN_W];

  // Pointer moves to the requester just after the winner.
  assign ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  assign owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;

  // --------------------------------------------------------------------------
  // Controller FSM with registered outputs
  // --------------------------------------------------------------------------
  // rsp_valid_q / rsp_last_q form the one-cycle delay that matches the ROM's
  // registered read: the beat issued in cycle C appears on rom_data in C+1,
  // exactly when these registers mark its owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      rem_q       <= '0;
      rom_addr_q  <= '0;
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      if (state_q == ST_BUSY) begin
        rsp_valid_q <= owner_onehot;
        rsp_last_q  <= (rem_q == '0);
      end else begin
        rsp_valid_q <= '0;
        rsp_last_q  <= 1'b0;
      end

      if (gnt_any) begin
        rom_addr_q <= gnt_addr;
        rem_q      <= gnt_len;
        owner_q    <= gnt_idx;
        ptr_q      <= ptr_d;
        state_q    <= ST_BUSY;
      end else if (state_q == ST_BUSY) begin
        if (rem_q != '0) begin
          // DEPTH is a power of two, so the natural overflow wraps the address.
          rom_addr_q <= rom_addr_q + 1'b1;
          rem_q      <= rem_q - 1'b1;
        end else begin
          state_q <= ST_IDLE;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready = gnt_onehot;
  assign rom_addr  = rom_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rom_data;

endmodule
`default_nettype wire
